// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like arbiter slice: transfer size codes,
// default bus widths and a constant-friendly ceil(log2) helper.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundles the per-channel master buses and the shared slave bus. The arbiter
// takes the slave modport (it serves the masters); the surrounding system uses master.
interface sram_like_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic [NUM_CH-1:0]        m_req;
  logic [NUM_CH-1:0]        m_wr;
  logic [2*NUM_CH-1:0]      m_size;
  logic [AW*NUM_CH-1:0]     m_addr;
  logic [DW*NUM_CH-1:0]     m_wdata;
  logic [DW/8*NUM_CH-1:0]   m_wstrb;
  logic [NUM_CH-1:0]        m_addr_ok;
  logic [NUM_CH-1:0]        m_data_ok;
  logic [DW-1:0]            m_rdata;

  logic                     s_req;
  logic                     s_wr;
  logic [1:0]               s_size;
  logic [AW-1:0]            s_addr;
  logic [DW-1:0]            s_wdata;
  logic [DW/8-1:0]          s_wstrb;
  logic                     s_addr_ok;
  logic                     s_data_ok;
  logic [DW-1:0]            s_rdata;

  logic                     err;

  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
    input  s_addr_ok, s_data_ok, s_rdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata, s_wstrb,
    output err
  );

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
    output s_addr_ok, s_data_ok, s_rdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_size, s_addr, s_wdata, s_wstrb,
    input  err
  );
endinterface

// File: rtl/sram_like_id_fifo.sv
// In-order FIFO of channel IDs for accepted requests; the head names the
// channel that owns the next slave response.
module sram_like_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW   = 1,
  localparam int CW   = clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  logic           pop,
  output logic [IDW-1:0] head_id,
  output logic           full,
  output logic           empty,
  output logic [CW-1:0]  count
);

  logic [IDW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // A pop on an empty FIFO is ignored so the pointers stay consistent
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates several SRAM-like masters onto one slave port, holding the grant
// until the slave accepts and routing responses back in issue order.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 1,
  parameter int AW              = AW_DEFAULT,
  parameter int DW              = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  sram_like_arbiter_if.slave bus
);

  localparam int IDW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int CW  = clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = DW / 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] lock_ch;
  logic [IDW-1:0] rr_ptr;
  logic           err_q;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] grant;
  logic           grant_valid;
  logic           s_req_int;
  logic           handshake;

  logic [IDW-1:0] head_id;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  // Round-robin searches upward from the channel after the last winner
  always_comb begin
    winner = '0;
    if (RR_MODE != 0) begin
      logic found;
      found = 1'b0;
      for (int off = 1; off <= NUM_CH; off++) begin
        int idx;
        idx = (int'(rr_ptr) + off) % NUM_CH;
        if (!found && bus.m_req[idx]) begin
          winner = IDW'(idx);
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (bus.m_req[i]) winner = IDW'(i);
      end
    end
  end

  always_comb begin
    if (state == ST_LOCKED) begin
      grant       = lock_ch;
      grant_valid = 1'b1;
    end else begin
      grant       = winner;
      grant_valid = (|bus.m_req) && !fifo_full;
    end
  end

  assign s_req_int = grant_valid && bus.m_req[grant] && !fifo_full;
  assign handshake = s_req_int && bus.s_addr_ok;

  always_comb begin
    bus.s_wr    = 1'b0;
    bus.s_size  = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    if (grant_valid) begin
      bus.s_wr    = bus.m_wr[grant];
      bus.s_size  = bus.m_size[int'(grant)*2 +: 2];
      bus.s_addr  = bus.m_addr[int'(grant)*AW +: AW];
      bus.s_wdata = bus.m_wdata[int'(grant)*DW +: DW];
      bus.s_wstrb = bus.m_wstrb[int'(grant)*SW +: SW];
    end
  end

  always_comb begin
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.m_addr_ok[i] = handshake && (grant == IDW'(i));
      bus.m_data_ok[i] = bus.s_data_ok && (fifo_count != '0) && (head_id == IDW'(i));
    end
  end

  assign bus.s_req   = s_req_int;
  assign bus.m_rdata = bus.s_rdata;
  assign bus.err     = err_q;

  // A master withdrawing its request while locked is a protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= IDW'(NUM_CH - 1);
      err_q   <= 1'b0;
    end else begin
      if (handshake) rr_ptr <= grant;
      if (bus.s_data_ok && fifo_empty) err_q <= 1'b1;
      if (state == ST_IDLE) begin
        if (s_req_int && !bus.s_addr_ok) begin
          state   <= ST_LOCKED;
          lock_ch <= grant;
        end
      end else begin
        if (!bus.m_req[lock_ch]) begin
          err_q <= 1'b1;
          state <= ST_IDLE;
        end else if (bus.s_addr_ok) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  sram_like_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .IDW   (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (handshake),
    .push_id (grant),
    .pop     (bus.s_data_ok),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: one round-robin instance for all
// scenarios plus a fixed-priority instance for the priority comparison.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  sram_like_arbiter_if #(.NUM_CH(2), .AW(32), .DW(32)) bus_rr ();
  sram_like_arbiter_if #(.NUM_CH(2), .AW(32), .DW(32)) bus_fp ();

  sram_like_arbiter #(
    .NUM_CH(2), .MAX_OUTSTANDING(4), .RR_MODE(1), .AW(32), .DW(32)
  ) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  sram_like_arbiter #(
    .NUM_CH(2), .MAX_OUTSTANDING(4), .RR_MODE(0), .AW(32), .DW(32)
  ) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_rr.m_req     = '0;
    bus_rr.m_wr      = '0;
    bus_rr.m_size    = {SZ_WORD, SZ_WORD};
    bus_rr.m_addr    = '0;
    bus_rr.m_wdata   = '0;
    bus_rr.m_wstrb   = '0;
    bus_rr.s_addr_ok = 1'b0;
    bus_rr.s_data_ok = 1'b0;
    bus_rr.s_rdata   = '0;
    bus_fp.m_req     = '0;
    bus_fp.m_wr      = '0;
    bus_fp.m_size    = {SZ_WORD, SZ_WORD};
    bus_fp.m_addr    = '0;
    bus_fp.m_wdata   = '0;
    bus_fp.m_wstrb   = '0;
    bus_fp.s_addr_ok = 1'b0;
    bus_fp.s_data_ok = 1'b0;
    bus_fp.s_rdata   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    tests_run++;
    if (bus_rr.s_req !== 1'b0 || bus_rr.m_addr_ok !== 2'b00 || bus_rr.m_data_ok !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: got s_req=%b addr_ok=%b data_ok=%b expected 0 00 00",
               bus_rr.s_req, bus_rr.m_addr_ok, bus_rr.m_data_ok);
    end
    tests_run++;
    if (bus_rr.s_addr !== 32'h0 || bus_rr.s_wr !== 1'b0 || bus_rr.s_size !== 2'b00 || bus_rr.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fields: got addr=%h wr=%b size=%b err=%b expected 0 0 0 0",
               bus_rr.s_addr, bus_rr.s_wr, bus_rr.s_size, bus_rr.err);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    bus_rr.m_req              = 2'b10;
    bus_rr.m_addr[63:32]      = 32'h0000_1000;
    bus_rr.s_addr_ok          = 1'b1;
    settle();
    tests_run++;
    if (bus_rr.m_addr_ok !== 2'b10 || bus_rr.s_addr !== 32'h0000_1000 || bus_rr.s_size !== SZ_WORD) begin
      tests_failed++;
      $display("[TB] FAIL single_addr: got addr_ok=%b addr=%h size=%b expected 10 00001000 10",
               bus_rr.m_addr_ok, bus_rr.s_addr, bus_rr.s_size);
    end
    tick();
    bus_rr.m_req     = 2'b00;
    bus_rr.s_addr_ok = 1'b0;
    tick();
    bus_rr.s_data_ok = 1'b1;
    bus_rr.s_rdata   = 32'hDEAD_BEEF;
    settle();
    tests_run++;
    if (bus_rr.m_data_ok !== 2'b10 || bus_rr.m_rdata !== 32'hDEAD_BEEF || bus_rr.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_data: got data_ok=%b rdata=%h err=%b expected 10 deadbeef 0",
               bus_rr.m_data_ok, bus_rr.m_rdata, bus_rr.err);
    end
    tick();
    bus_rr.s_data_ok = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr [4];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    do_reset();
    bus_rr.m_req = 2'b11; bus_rr.s_addr_ok = 1'b1;
    bus_rr.m_addr = {32'h0000_0200, 32'h0000_0100};
    bus_fp.m_req = 2'b11; bus_fp.s_addr_ok = 1'b1;
    bus_fp.m_addr = {32'h0000_0200, 32'h0000_0100};
    for (int c = 0; c < 4; c++) begin
      settle();
      tests_run++;
      if (bus_rr.m_addr_ok !== exp_rr[c]) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", c, bus_rr.m_addr_ok, exp_rr[c]);
      end
      tests_run++;
      if (bus_fp.m_addr_ok !== 2'b01 || bus_fp.s_addr !== 32'h0000_0100) begin
        tests_failed++;
        $display("[TB] FAIL fixed_grant%0d: got %b addr %h expected 01 addr 00000100",
                 c, bus_fp.m_addr_ok, bus_fp.s_addr);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus_rr.m_addr = {32'h0000_2000, 32'h0000_3000};
    bus_rr.m_req  = 2'b10;
    for (int c = 0; c < 3; c++) begin
      settle();
      tests_run++;
      if (bus_rr.s_req !== 1'b1 || bus_rr.s_addr !== 32'h0000_2000 || bus_rr.m_addr_ok !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL lock_hold%0d: got req=%b addr=%h addr_ok=%b expected 1 00002000 00",
                 c, bus_rr.s_req, bus_rr.s_addr, bus_rr.m_addr_ok);
      end
      tick();
      bus_rr.m_req = 2'b11;
    end
    bus_rr.s_addr_ok = 1'b1;
    settle();
    tests_run++;
    if (bus_rr.m_addr_ok !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL lock_release: got %b expected 10", bus_rr.m_addr_ok);
    end
    tick();
    bus_rr.m_req = 2'b01;
    settle();
    tests_run++;
    if (bus_rr.m_addr_ok !== 2'b01 || bus_rr.s_addr !== 32'h0000_3000) begin
      tests_failed++;
      $display("[TB] FAIL lock_next: got addr_ok=%b addr=%h expected 01 00003000",
               bus_rr.m_addr_ok, bus_rr.s_addr);
    end
    tick();
  endtask

  task automatic test_lock_drop();
    do_reset();
    bus_rr.m_req = 2'b01;
    tick();
    bus_rr.m_req = 2'b00;
    settle();
    tests_run++;
    if (bus_rr.s_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_req: got s_req=%b expected 0", bus_rr.s_req);
    end
    tick();
    bus_rr.m_req = 2'b10; bus_rr.s_addr_ok = 1'b1;
    settle();
    tests_run++;
    if (bus_rr.err !== 1'b1 || bus_rr.m_addr_ok !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL drop_err: got err=%b addr_ok=%b expected 1 10", bus_rr.err, bus_rr.m_addr_ok);
    end
    tick();
  endtask

  task automatic test_full();
    do_reset();
    bus_rr.s_addr_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_rr.m_req = (c == 0) ? 2'b10 : 2'b01;
      settle();
      tests_run++;
      if (c < 4 && bus_rr.m_addr_ok !== ((c == 0) ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL full_fill%0d: got %b", c, bus_rr.m_addr_ok);
      end else if (c == 4 && (bus_rr.s_req !== 1'b0 || bus_rr.m_addr_ok !== 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL full_block: got req=%b addr_ok=%b expected 0 00", bus_rr.s_req, bus_rr.m_addr_ok);
      end
      tick();
    end
    bus_rr.s_data_ok = 1'b1;
    settle();
    tests_run++;
    if (bus_rr.s_req !== 1'b0 || bus_rr.m_data_ok !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL full_pop: got req=%b data_ok=%b expected 0 10", bus_rr.s_req, bus_rr.m_data_ok);
    end
    tick();
    bus_rr.s_data_ok = 1'b0;
    settle();
    tests_run++;
    if (bus_rr.s_req !== 1'b1 || bus_rr.m_addr_ok !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL full_resume: got req=%b addr_ok=%b expected 1 01", bus_rr.s_req, bus_rr.m_addr_ok);
    end
    tick();
  endtask

  task automatic test_ordering_and_error();
    logic [1:0] order [3];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
    do_reset();
    bus_rr.s_addr_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus_rr.m_req = order[c];
      tick();
    end
    bus_rr.m_req = 2'b00; bus_rr.s_addr_ok = 1'b0;
    bus_rr.s_data_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus_rr.s_rdata = 32'hA000_0000 + 32'(c);
      settle();
      tests_run++;
      if (bus_rr.m_data_ok !== order[c] || bus_rr.m_rdata !== 32'hA000_0000 + 32'(c)) begin
        tests_failed++;
        $display("[TB] FAIL order%0d: got data_ok=%b rdata=%h expected %b %h",
                 c, bus_rr.m_data_ok, bus_rr.m_rdata, order[c], 32'hA000_0000 + 32'(c));
      end
      tick();
    end
    settle();
    tests_run++;
    if (bus_rr.m_data_ok !== 2'b00 || bus_rr.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_pop: got data_ok=%b err=%b expected 00 0", bus_rr.m_data_ok, bus_rr.err);
    end
    tick();
    bus_rr.s_data_ok = 1'b0;
    settle();
    tests_run++;
    if (bus_rr.err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL empty_err: got err=%b expected 1", bus_rr.err);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    bus_rr.m_req = 2'b01; bus_rr.s_addr_ok = 1'b1;
    tick();
    tick();
    do_reset();
    settle();
    tests_run++;
    if (bus_rr.err !== 1'b0 || bus_rr.s_req !== 1'b0 || bus_rr.m_addr_ok !== 2'b00 || bus_rr.m_data_ok !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset: got err=%b req=%b addr_ok=%b data_ok=%b expected 0 0 00 00",
               bus_rr.err, bus_rr.s_req, bus_rr.m_addr_ok, bus_rr.m_data_ok);
    end
    tick();
    bus_rr.s_data_ok = 1'b1;
    settle();
    tests_run++;
    if (bus_rr.m_data_ok !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midop_dropped: got data_ok=%b expected 00", bus_rr.m_data_ok);
    end
    tick();
    bus_rr.s_data_ok = 1'b0;
    settle();
    tests_run++;
    if (bus_rr.err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midop_err: got err=%b expected 1", bus_rr.err);
    end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_full();
    test_ordering_and_error();
    test_reset_midop();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
